// File: rtl/mts_sysref_ctrl.sv
// SYSREF gating controller: forwards a counted (or continuous) burst of whole SYSREF pulses.
// Define MTS_SYSREF_PERIOD_CHK_EN to build the optional SYSREF period monitor.
module mts_sysref_ctrl #(
  parameter int PULSE_W = 8,
  parameter int TMO_W   = 20
) (
  input  logic               FPGAPL_ref_clk,
  input  logic               rst_n,
  input  logic               sysref_sync,
  input  logic               start,
  input  logic               abort,
  input  logic [PULSE_W-1:0] num_pulses,
  input  logic [TMO_W-1:0]   timeout_cyc,
  output logic               sysref_gated,
  output logic               gate_en,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [PULSE_W-1:0] pulse_cnt,
  output logic               period_err
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_RUN, S_DONE, S_ERR} state_t;

  state_t             state, state_nxt;
  logic               sysref_d;
  logic               rise, fall;
  logic [PULSE_W-1:0] num_lat;
  logic [TMO_W-1:0]   tmo_lat;
  logic [TMO_W-1:0]   timer;
  logic               start_acc, last_hit, expire;
  logic               run_nxt, tmr_reload;

  function automatic logic [PULSE_W-1:0] sat_inc(input logic [PULSE_W-1:0] v);
    return (&v) ? v : v + PULSE_W'(1);
  endfunction

  assign rise      = sysref_sync & ~sysref_d;
  assign fall      = ~sysref_sync & sysref_d;
  assign start_acc = start & ~abort & ~busy;
  assign last_hit  = (num_lat != '0) && (pulse_cnt == num_lat);
  // A rise in the same cycle as expiry reloads the timer instead of erroring.
  assign expire    = busy && (tmo_lat != '0) && (timer == tmo_lat - TMO_W'(1)) && !rise;

  always_ff @(posedge FPGAPL_ref_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_ALIGN;
        S_ALIGN: begin
          if (!sysref_sync) state_nxt = S_RUN;
          else if (expire)  state_nxt = S_ERR;
        end
        S_RUN: begin
          if (fall && last_hit) state_nxt = S_DONE;
          else if (expire)      state_nxt = S_ERR;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == S_ALIGN) || (state == S_RUN);
    run_nxt    = (state_nxt == S_RUN);
    tmr_reload = start_acc || ((state == S_ALIGN) && (state_nxt == S_RUN)) || (busy && rise);
  end

  // Gate is registered from the next state so sysref_gated always equals sysref_d & gate_en.
  always_ff @(posedge FPGAPL_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      sysref_d     <= 1'b0;
      sysref_gated <= 1'b0;
      gate_en      <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      pulse_cnt    <= '0;
      num_lat      <= '0;
      tmo_lat      <= '0;
      timer        <= '0;
    end else begin
      sysref_d     <= sysref_sync;
      gate_en      <= run_nxt;
      sysref_gated <= sysref_sync & run_nxt;
      if (start_acc) begin
        num_lat     <= num_pulses;
        tmo_lat     <= timeout_cyc;
        pulse_cnt   <= '0;
        done        <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (abort)
          done <= 1'b0;
        else if ((state == S_RUN) && (state_nxt == S_DONE))
          done <= 1'b1;
        if (!abort && busy && (state_nxt == S_ERR))
          timeout_err <= 1'b1;
        if (!abort && (state == S_RUN) && rise)
          pulse_cnt <= sat_inc(pulse_cnt);
      end
      if (tmr_reload)
        timer <= '0;
      else if (busy)
        timer <= timer + TMO_W'(1);
    end
  end

`ifdef MTS_SYSREF_PERIOD_CHK_EN
  logic [TMO_W-1:0] per_cnt, per_ref;
  logic [TMO_W:0]   per_a, per_b;

  assign per_a = {1'b0, per_cnt};
  assign per_b = {1'b0, per_ref};

  // The first rise-to-rise interval in RUN becomes the reference period.
  always_ff @(posedge FPGAPL_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      per_ref    <= '0;
      period_err <= 1'b0;
    end else if (start_acc) begin
      per_cnt    <= '0;
      period_err <= 1'b0;
    end else if ((state == S_RUN) && !abort) begin
      if (rise) begin
        per_cnt <= '0;
        if (pulse_cnt == PULSE_W'(1))
          per_ref <= per_cnt;
        else if ((pulse_cnt > PULSE_W'(1)) &&
                 ((per_a > per_b + 1'b1) || (per_b > per_a + 1'b1)))
          period_err <= 1'b1;
      end else if (!(&per_cnt)) begin
        per_cnt <= per_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_mts_sysref_ctrl.sv
// Scoreboard bench for mts_sysref_ctrl: per-sequence expectations from a waveform-walking model.
module tb_mts_sysref_ctrl;

  localparam int CNT_MAX = 255;

  logic       FPGAPL_ref_clk;
  logic       rst_n;
  logic       sysref_sync;
  logic       start;
  logic       abort;
  logic [7:0] num_pulses;
  logic [19:0] timeout_cyc;
  logic       sysref_gated;
  logic       gate_en;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [7:0] pulse_cnt;
  logic       period_err;

  mts_sysref_ctrl dut (
    .FPGAPL_ref_clk (FPGAPL_ref_clk),
    .rst_n          (rst_n),
    .sysref_sync    (sysref_sync),
    .start          (start),
    .abort          (abort),
    .num_pulses     (num_pulses),
    .timeout_cyc    (timeout_cyc),
    .sysref_gated   (sysref_gated),
    .gate_en        (gate_en),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .pulse_cnt      (pulse_cnt),
    .period_err     (period_err)
  );

  initial FPGAPL_ref_clk = 1'b0;
  always #5 FPGAPL_ref_clk = ~FPGAPL_ref_clk;

  typedef struct {
    int id;
    int done;
    int terr;
    int cnt;
    int highs;
    int rises;
    int perr;
    int endk;
    int endc;
  } exp_t;

  exp_t expq[$];
  bit   wq[$];
  int   ivl[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   seq_id = 0;
  bit   mon_en = 1'b1;

  always @(posedge FPGAPL_ref_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  // SYSREF waveform: z lows, lead_hi highs (a partial pulse), one pulse per ivl entry, tail lows.
  task automatic build_wave(input int z, input int lead_hi, input int hi, input int tail);
    wq.delete();
    repeat (z) wq.push_back(1'b0);
    repeat (lead_hi) wq.push_back(1'b1);
    foreach (ivl[i]) begin
      repeat (ivl[i] - hi) wq.push_back(1'b0);
      repeat (hi) wq.push_back(1'b1);
    end
    repeat (tail) wq.push_back(1'b0);
  endtask

  // Walks the sampled waveform with the sequence rules; start sampled at s0, abort at a.
  function automatic exp_t model(input int s0, input int a, input int num, input int tmo);
    exp_t e;
    int   phase, last_rl, rprev, refp, iv;
    bit   w, wp, rs, fl, ended;
    e.id = 0; e.done = 0; e.terr = 0; e.cnt = 0; e.highs = 0; e.rises = 0;
    e.perr = 0; e.endk = a; e.endc = 0;
    phase = 0; last_rl = s0; rprev = -1; refp = -1; ended = 1'b0;
    for (int k = s0 + 1; k < a && !ended; k++) begin
      w = wq[k]; wp = wq[k-1];
      rs = w & ~wp; fl = ~w & wp;
      if (phase == 0) begin
        if (!w) begin
          phase = 1; last_rl = k;
        end else if (rs) begin
          last_rl = k;
        end else if (tmo != 0 && k - last_rl == tmo) begin
          e.terr = 1; e.endk = k; ended = 1'b1;
        end
      end else begin
        if (num != 0 && e.cnt == num && fl) begin
          e.done = 1; e.endk = k; ended = 1'b1;
        end else if (rs) begin
          e.rises++;
          e.cnt = (e.cnt == CNT_MAX) ? CNT_MAX : e.cnt + 1;
          last_rl = k;
`ifdef MTS_SYSREF_PERIOD_CHK_EN
          if (rprev >= 0) begin
            iv = k - rprev;
            if (refp < 0) refp = iv;
            else if (iv > refp + 1 || refp > iv + 1) e.perr = 1;
          end
`endif
          rprev = k;
        end else if (tmo != 0 && k - last_rl == tmo) begin
          e.terr = 1; e.endk = k; ended = 1'b1;
        end
        if (!ended && w) e.highs++;
      end
    end
    return e;
  endfunction

  task automatic run_seq(input int s0, input int a, input int num, input int tmo, input bit do_x);
    exp_t e;
    int   x;
    e = model(s0, a, num, tmo);
    x = do_x ? int'($urandom_range(s0 + 1, e.endk)) : -1;
    @(negedge FPGAPL_ref_clk);
    e.endc = cyc + e.endk + 1;
    e.id = seq_id;
    seq_id++;
    expq.push_back(e);
    for (int k = 0; k < wq.size(); k++) begin
      if (k > 0) @(negedge FPGAPL_ref_clk);
      sysref_sync = wq[k];
      start = (k == s0) || (k == x);
      abort = (k == a);
      if (k == s0) begin
        num_pulses  = 8'(num);
        timeout_cyc = 20'(tmo);
      end else if (k == s0 + 1) begin
        num_pulses  = 8'($urandom);
        timeout_cyc = 20'($urandom);
      end
    end
    @(negedge FPGAPL_ref_clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Monitor: every busy fall closes a sequence and is scored against the oldest expectation.
  initial begin
    bit    pb, pg;
    int    highs, rises, n;
    exp_t  e;
    string p;
    pb = 1'b0; pg = 1'b0; highs = 0; rises = 0;
    forever begin
      @(negedge FPGAPL_ref_clk);
      if (!mon_en) begin
        pb = 1'b0; pg = 1'b0; highs = 0; rises = 0;
      end else begin
        if (sysref_gated) highs++;
        if (sysref_gated && !pg) rises++;
        pg = sysref_gated;
        if (pb && !busy) begin
          n = expq.size();
          chk("seq_pending", int'(n > 0), 1);
          if (n > 0) begin
            e = expq.pop_front();
            p = $sformatf("seq%0d.", e.id);
            chk({p, "done"}, int'(done), e.done);
            chk({p, "timeout_err"}, int'(timeout_err), e.terr);
            chk({p, "pulse_cnt"}, int'(pulse_cnt), e.cnt);
            chk({p, "gated_high_cycles"}, highs, e.highs);
            chk({p, "gated_pulses"}, rises, e.rises);
            chk({p, "period_err"}, int'(period_err), e.perr);
            chk({p, "end_cycle"}, cyc, e.endc);
            chk({p, "gate_en"}, int'(gate_en), 0);
          end
          highs = 0; rises = 0;
        end
        pb = busy;
      end
    end
  end

  initial begin
    bit seen;
    rst_n = 1'b0; sysref_sync = 1'b0; start = 1'b0; abort = 1'b0;
    num_pulses = '0; timeout_cyc = '0;
    repeat (3) @(negedge FPGAPL_ref_clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.gate_en", int'(gate_en), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.timeout_err", int'(timeout_err), 0);
    chk("rst.pulse_cnt", int'(pulse_cnt), 0);
    chk("rst.sysref_gated", int'(sysref_gated), 0);
    chk("rst.period_err", int'(period_err), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge FPGAPL_ref_clk);
    chk("post_rst.busy", int'(busy), 0);

    start = 1'b1; abort = 1'b1; num_pulses = 8'd3;
    @(negedge FPGAPL_ref_clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort.busy", int'(busy), 0);
    @(negedge FPGAPL_ref_clk);
    chk("start_abort.busy2", int'(busy), 0);

    // Counted burst: 4 pulses of period 16, 8 high.
    ivl = {16, 16, 16, 16, 16, 16};
    build_wave(4, 0, 8, 8);
    run_seq(2, wq.size() - 1, 4, 1000, 1'b0);
    // Start while SYSREF is high: the partial pulse must not be forwarded.
    ivl = {16, 16, 16};
    build_wave(3, 6, 8, 6);
    run_seq(5, wq.size() - 1, 2, 0, 1'b0);
    // Continuous mode, 300 pulses, pulse_cnt saturates, then abort.
    ivl.delete();
    repeat (300) ivl.push_back(8);
    build_wave(4, 0, 4, 4);
    run_seq(2, wq.size() - 1, 0, 0, 1'b0);
    // SYSREF stops after 2 pulses with timeout 50.
    ivl = {16, 16};
    build_wave(4, 0, 8, 100);
    run_seq(2, wq.size() - 1, 0, 50, 1'b0);
    // Period pattern 16,16,19 then 16,17,15 (also clears the previous timeout).
    ivl = {16, 16, 16, 19, 16};
    build_wave(4, 0, 8, 10);
    run_seq(2, wq.size() - 1, 0, 0, 1'b0);
    ivl = {16, 16, 17, 15, 16};
    build_wave(4, 0, 8, 10);
    run_seq(2, wq.size() - 1, 0, 0, 1'b0);

    for (int s = 0; s < 22; s++) begin
      int per, hi, np, z, lh, tl, num, tmo, s0, a, sel;
      per = $urandom_range(5, 20);
      hi  = $urandom_range(1, per - 3);
      np  = $urandom_range(0, 8);
      ivl.delete();
      for (int i = 0; i < np; i++)
        ivl.push_back(per + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) - 2 : 0));
      z  = $urandom_range(1, 6);
      lh = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5)) : 0;
      tl = $urandom_range(2, 80);
      build_wave(z, lh, hi, tl);
      num = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       tmo = 0;
        1:       tmo = $urandom_range(3, 8);
        2:       tmo = $urandom_range(10, 60);
        default: tmo = 1000;
      endcase
      s0 = $urandom_range(1, z + lh);
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(s0 + 1, wq.size() - 1)) : wq.size() - 1;
      run_seq(s0, a, num, tmo, $urandom_range(0, 2) == 0);
    end
    repeat (4) @(negedge FPGAPL_ref_clk);
    chk("leftover_expected", expq.size(), 0);

    // Asynchronous reset in the middle of a forwarded pulse.
    mon_en = 1'b0;
    num_pulses = '0; timeout_cyc = '0; start = 1'b1;
    @(negedge FPGAPL_ref_clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      sysref_sync = ((i % 16) >= 8);
      @(negedge FPGAPL_ref_clk);
      if (sysref_gated) seen = 1'b1;
    end
    chk("arst.gated_seen", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.sysref_gated", int'(sysref_gated), 0);
    chk("arst.gate_en", int'(gate_en), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.pulse_cnt", int'(pulse_cnt), 0);
    @(negedge FPGAPL_ref_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sysref_sync = ((i % 8) >= 4);
      @(negedge FPGAPL_ref_clk);
    end
    chk("arst_release.busy", int'(busy), 0);
    chk("arst_release.sysref_gated", int'(sysref_gated), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
